axi_sram_slave: RTL and testbench

- AXI3 32-bit slave with on-chip SRAM storage. It is the responder end of the core's AXI master port.
- Used as the simulation/FPGA memory behind the core top for bring-up and trace-compare runs.
- Independent read and write engines, one outstanding transaction each; FIXED/INCR/WRAP bursts up to 16 beats.
- lock/cache/prot signals are not ports; they are ignored.

---
 rtl/axi_sram_slave.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 32-bit slave backed by on-chip SRAM, one outstanding read and write
module axi_sram_slave #(
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_WIDTH-1:0] arid,
  input  logic [31:0]         araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_WIDTH-1:0] rid,
  output logic [31:0]         rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ID_WIDTH-1:0] awid,
  input  logic [31:0]         awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_WIDTH-1:0] wid,
  input  logic [31:0]         wdata,
  input  logic [3:0]          wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_WIDTH-1:0] bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);
  localparam int WORDS = 1 << (ADDR_WIDTH - 2);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [31:0] mem [WORDS];

  // Next byte address of a burst; reserved burst type falls back to INCR (its data is never trusted)
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step;
    logic [31:0] mask;
    step = 32'd1 << size;
    mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (addr & ~mask) | ((addr + step) & mask);
      default: next_addr = addr + step;
    endcase
  endfunction

  // A request this memory can honour; anything else is answered with SLVERR for every beat
  function automatic logic req_legal(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    logic wrap_ok;
    wrap_ok = (burst != 2'b10) || (len == 8'd1) || (len == 8'd3) ||
              (len == 8'd7) || (len == 8'd15);
    req_legal = (burst != 2'b11) && (size <= 3'd2) && (len <= 8'd15) && wrap_ok;
  endfunction

  // ---------------- read engine ----------------
  r_state_t    r_state;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_beat;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [31:0] r_next;

  assign r_next = next_addr(r_addr, r_len, r_size, r_burst);

  // Read FSM: accept AR, then present one registered beat at a time until rlast is taken
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      rid     <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_size  <= '0;
      r_burst <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            rid     <= arid;
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_beat  <= '0;
            rdata   <= mem[araddr[ADDR_WIDTH-1:2]];
            rresp   <= req_legal(arlen, arsize, arburst) ? RESP_OKAY : RESP_SLVERR;
            rlast   <= (arlen == 8'd0);
            rvalid  <= 1'b1;
            arready <= 1'b0;
            r_state <= R_BURST;
          end
        end
        R_BURST: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr <= r_next;
              rdata  <= mem[r_next[ADDR_WIDTH-1:2]];
              r_beat <= r_beat + 8'd1;
              rlast  <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- write engine ----------------
  w_state_t    w_state;
  logic [31:0] w_addr;
  logic [7:0]  w_len;
  logic [8:0]  w_beat;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_legal;
  logic        w_err;
  logic        w_fire;
  logic        w_err_next;
  logic        mem_we;

  assign w_fire     = wvalid && wready;
  assign w_err_next = w_err || (wid != bid) || (w_beat > {1'b0, w_len}) ||
                      (wlast && (w_beat != {1'b0, w_len}));
  assign mem_we     = w_fire && w_legal && (w_beat <= {1'b0, w_len});

  // Write FSM: accept AW, absorb W beats up to wlast, then hold the response until taken
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      bid     <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_legal <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            bid     <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_legal <= req_legal(awlen, awsize, awburst);
            w_beat  <= '0;
            w_err   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            if (w_beat != 9'h1FF) w_beat <= w_beat + 9'd1;
            w_err  <= w_err_next;
            if (wlast) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= (w_err_next || !w_legal) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // SRAM byte-lane write port; contents deliberately survive reset
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[w_addr[ADDR_WIDTH-1:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - randomized self-checking bench for axi_sram_slave
module tb_axi_sram_slave;
  localparam int AW = 16;
  localparam int IW = 4;
  localparam int NW = 1 << (AW - 2);

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [IW-1:0] arid = '0, awid = '0, wid = '0;
  logic [31:0]   araddr = '0, awaddr = '0, wdata = '0;
  logic [7:0]    arlen = '0, awlen = '0;
  logic [2:0]    arsize = '0, awsize = '0;
  logic [1:0]    arburst = '0, awburst = '0;
  logic          arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic          rready = 1'b0, bready = 1'b0;
  logic [3:0]    wstrb = '0;
  logic          arready, awready, rlast, rvalid, wready, bvalid;
  logic [IW-1:0] rid, bid;
  logic [31:0]   rdata;
  logic [1:0]    rresp, bresp;

  always #5 aclk = ~aclk;

  axi_sram_slave #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference memory: byte address -> aligned word, upper bits alias
  logic [31:0] mdl [NW];
  logic [31:0] wd [64];
  logic [3:0]  ws [64];
  logic [31:0] rbuf [$];

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW-1:2]);
  endfunction

  function automatic logic is_legal(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic ok;
    ok = (burst != 2'b11) && (size <= 3'd2) && (len <= 8'd15);
    if (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ok = 1'b0;
    return ok;
  endfunction

  // Byte address of beat i, from the burst definition as offsets into a window
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst, input int i);
    logic [31:0] step, bound, base, res;
    step = 32'd1 << size;
    if (burst == 2'b00) res = a;
    else if (burst == 2'b10) begin
      bound = (32'(len) + 32'd1) * step;
      base  = a - (a % bound);
      res   = base + ((a - base + 32'(i) * step) % bound);
    end else res = a + 32'(i) * step;
    return res;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [IW-1:0] id, input int nbeats,
                          input int bad_wid_beat);
    int n, i, k;
    logic lg, exp_err, fire;
    lg = is_legal(len, size, burst);
    exp_err = !lg || (nbeats != int'(len) + 1) || (bad_wid_beat >= 0 && bad_wid_beat < nbeats);
    for (int j = 0; j < nbeats; j++) begin
      if (lg && j <= int'(len)) begin
        k = widx(beat_addr(addr, len, size, burst, j));
        for (int b = 0; b < 4; b++) if (ws[j][b]) mdl[k][8*b +: 8] = wd[j][8*b +: 8];
      end
    end
    awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 200) begin @(posedge aclk); #1; n++; end
    check("aw_ready", awready, 1'b1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    i = 0; n = 0;
    while (i < nbeats && n < 1000) begin
      wvalid = ($urandom_range(0, 3) != 0);
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == nbeats - 1);
      wid = (i == bad_wid_beat) ? (id ^ 4'h1) : id;
      fire = wvalid && wready;
      @(posedge aclk); #1;
      n++;
      if (fire) i++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("w_beats", i, nbeats);
    n = 0;
    while (!bvalid && n < 200) begin @(posedge aclk); #1; n++; end
    check("bvalid", bvalid, 1'b1);
    repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
    check("bvalid_hold", bvalid, 1'b1);
    check("bresp", bresp, exp_err ? 2'b10 : 2'b00);
    check("bid", bid, id);
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    check("bvalid_clear", bvalid, 1'b0);
  endtask

  // mode 0: random rready, mode 1: rready toggles 1,0,1,0...
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [IW-1:0] id, input int mode);
    int n, beat;
    logic lg, rr, fire;
    lg = is_legal(len, size, burst);
    rbuf.delete();
    araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 200) begin @(posedge aclk); #1; n++; end
    check("ar_ready", arready, 1'b1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    check("rvalid_first", rvalid, 1'b1);
    beat = 0; n = 0;
    while (beat <= int'(len) && n < 3000) begin
      rr = (mode == 1) ? ((n % 2) == 0) : ($urandom_range(0, 2) != 0);
      rready = rr;
      if (rvalid) begin
        if (lg) check("rdata", rdata, mdl[widx(beat_addr(addr, len, size, burst, beat))]);
        check("rresp", rresp, lg ? 2'b00 : 2'b10);
        check("rlast", rlast, beat == int'(len));
        check("rid", rid, id);
      end
      fire = rvalid && rr;
      if (fire) rbuf.push_back(rdata);
      @(posedge aclk); #1;
      n++;
      if (fire) beat++;
    end
    rready = 1'b0;
    check("r_beats", beat, int'(len) + 1);
    check("rvalid_clear", rvalid, 1'b0);
  endtask

  task automatic fill_random(input int n);
    for (int j = 0; j < n; j++) begin
      wd[j] = $urandom;
      ws[j] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          nb, bad;

    // Reset values
    #2;
    check("rst_arready", arready, 1'b0);
    check("rst_awready", awready, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    @(posedge aclk); @(posedge aclk); #2;
    aresetn = 1'b1;
    check("rel_arready_pre", arready, 1'b0);
    @(posedge aclk); #1;
    check("rel_arready", arready, 1'b1);
    check("rel_awready", awready, 1'b1);

    // Single write/read
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(32'h10, 8'd0, 3'd2, 2'b01, 4'h3, 1, -1);
    do_read(32'h10, 8'd0, 3'd2, 2'b01, 4'h5, 0);
    check("single_rdata", rbuf[0], 32'hDEADBEEF);

    // Byte strobes
    wd[0] = 32'h11223344; ws[0] = 4'b0101;
    do_write(32'h10, 8'd0, 3'd2, 2'b01, 4'h1, 1, -1);
    do_read(32'h10, 8'd0, 3'd2, 2'b01, 4'h2, 0);
    check("strb_word", rbuf[0], 32'hDE22BE44);

    // INCR burst with toggling rready
    for (int j = 0; j < 4; j++) begin wd[j] = 32'(j + 1); ws[j] = 4'hF; end
    do_write(32'h100, 8'd3, 3'd2, 2'b01, 4'h7, 4, -1);
    do_read(32'h100, 8'd3, 3'd2, 2'b01, 4'h8, 1);
    for (int j = 0; j < 4; j++) check("incr_beat", rbuf[j], 32'(j + 1));

    // WRAP
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
    do_write(32'h20, 8'd3, 3'd2, 2'b01, 4'h0, 4, -1);
    do_read(32'h28, 8'd3, 3'd2, 2'b10, 4'h9, 0);
    check("wrap0", rbuf[0], 32'hC);
    check("wrap1", rbuf[1], 32'hD);
    check("wrap2", rbuf[2], 32'hA);
    check("wrap3", rbuf[3], 32'hB);

    // Errors: reserved burst read, illegal write leaves SRAM alone, early wlast, wid mismatch, extra beats
    do_read(32'h20, 8'd1, 3'd2, 2'b11, 4'h4, 0);
    wd[0] = 32'h55555555; wd[1] = 32'h66666666; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(32'h20, 8'd1, 3'd2, 2'b11, 4'h2, 2, -1);
    do_read(32'h20, 8'd1, 3'd2, 2'b01, 4'h4, 0);
    check("illegal_nowrite0", rbuf[0], 32'hA);
    check("illegal_nowrite1", rbuf[1], 32'hB);
    fill_random(4);
    do_write(32'h40, 8'd1, 3'd2, 2'b01, 4'h6, 1, -1);
    do_write(32'h48, 8'd1, 3'd2, 2'b01, 4'h6, 2, 1);
    do_write(32'h50, 8'd1, 3'd2, 2'b01, 4'h6, 3, -1);
    do_read(32'h40, 8'd5, 3'd2, 2'b01, 4'h1, 0);

    // INCR wraps at the top of the SRAM, aliased upper address bits
    fill_random(2);
    do_write(32'h0000FFFC, 8'd1, 3'd2, 2'b01, 4'h3, 2, -1);
    do_read(32'h0003FFFC, 8'd1, 3'd2, 2'b01, 4'h3, 0);
    check("top_wrap_word0", rbuf[1], mdl[0]);

    // Initialise the 0x000-0xFFF region for random traffic
    for (int blk = 0; blk < 64; blk++) begin
      for (int j = 0; j < 16; j++) begin wd[j] = $urandom; ws[j] = 4'hF; end
      do_write(32'(blk * 64), 8'd15, 3'd2, 2'b01, 4'($urandom), 16, -1);
    end

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      size = 3'($urandom_range(0, 2));
      burst = 2'($urandom_range(0, 2));
      if (burst == 2'b10) begin
        case ($urandom_range(0, 3))
          0: len = 8'd1;
          1: len = 8'd3;
          2: len = 8'd7;
          default: len = 8'd15;
        endcase
      end else len = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: burst = 2'b11;
          1: size = 3'($urandom_range(3, 7));
          2: begin burst = 2'b01; len = 8'($urandom_range(16, 20)); end
          default: begin burst = 2'b10; len = 8'd2; end
        endcase
      end
      a = {16'($urandom), 16'($urandom_range(0, 32'hEFF))};
      nb = int'(len) + 1;
      bad = -1;
      case ($urandom_range(0, 9))
        0: if (len > 0) nb = int'(len);
        1: nb = int'(len) + 2;
        2: bad = $urandom_range(0, int'(len));
        default: ;
      endcase
      fill_random(nb);
      do_write(a, len, size, burst, 4'($urandom), nb, bad);
      do_read(a, len, size, burst, 4'($urandom), 0);
    end

    // Concurrent read and write on disjoint regions
    fill_random(16);
    fork
      do_write(32'h800, 8'd15, 3'd2, 2'b01, 4'hA, 16, -1);
      do_read(32'h100, 8'd15, 3'd2, 2'b01, 4'hB, 0);
    join
    do_read(32'h800, 8'd15, 3'd2, 2'b01, 4'hC, 0);

    // Reset in the middle of an 8-beat read
    araddr = 32'h200; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arid = 4'hD; arvalid = 1'b1;
    nb = 0;
    while (!arready && nb < 200) begin @(posedge aclk); #1; nb++; end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    rready = 1'b1;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    check("mid_rvalid", rvalid, 1'b1);
    check("mid_rdata", rdata, mdl[widx(32'h208)]);
    aresetn = 1'b0;
    #1;
    check("mid_rst_rvalid", rvalid, 1'b0);
    check("mid_rst_rlast", rlast, 1'b0);
    check("mid_rst_arready", arready, 1'b0);
    check("mid_rst_awready", awready, 1'b0);
    rready = 1'b0;
    @(posedge aclk); @(posedge aclk); #1;
    aresetn = 1'b1;
    check("mid_rel_arready_pre", arready, 1'b0);
    @(posedge aclk); #1;
    check("mid_rel_arready", arready, 1'b1);
    do_read(32'h200, 8'd7, 3'd2, 2'b01, 4'hE, 0);
    do_read(32'h100, 8'd3, 3'd2, 2'b01, 4'hF, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
